// File: rtl/wb_axis_requester_if.sv
// Bus bundle for the requester: Wishbone slave side plus the request/response byte streams.
// Signal names and directions are as seen from the requester (the slave modport).
interface wb_axis_requester_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );
endinterface

// File: rtl/wb_axis_requester.sv
// Wishbone slave that turns each single-word access into a request byte frame and completes
// the cycle from the echoed response frame (ack on a clean echo, err on mismatch or timeout).
module wb_axis_requester #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  CMD_READ  = 8'hA1,
  parameter logic [7:0]  CMD_WRITE = 8'hA2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  wb_axis_requester_if.slave bus,
  output logic               o_busy
);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StTx, StRx, StResp} state_e;

  state_e        state_q, state_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d, rd_q, rd_d, dat_o_q, dat_o_d;
  logic          we_q, we_d, err_flag_q, err_flag_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d, sready_q, sready_d;
  logic          ack_q, ack_d, err_q, err_d, busy_q, busy_d;

  logic [3:0] tx_last, rx_last;
  logic       rx_fire, rx_bad, rx_err, unused_sel;

  // Byte idx of a frame; the response echo uses the same layout for bytes 0..6.
  function automatic logic [7:0] frame_byte(input logic we, input logic [31:0] adr,
                                            input logic [31:0] dat, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = we ? CMD_WRITE : CMD_READ;
      4'd1:    b = adr[31:24];
      4'd2:    b = adr[23:16];
      4'd3:    b = adr[15:8];
      4'd4:    b = adr[7:0];
      4'd5:    b = 8'h00;
      4'd6:    b = 8'h01;
      4'd7:    b = dat[31:24];
      4'd8:    b = dat[23:16];
      4'd9:    b = dat[15:8];
      4'd10:   b = dat[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign unused_sel = ^bus.wb_sel_i;
  assign tx_last    = we_q ? 4'd10 : 4'd6;
  assign rx_last    = we_q ? 4'd6 : 4'd10;
  assign rx_fire    = bus.s_axis_tvalid & sready_q;
  assign rx_bad     = (idx_q < 4'd7) &&
                      (bus.s_axis_tdata != frame_byte(we_q, adr_q, dat_q, idx_q));
  assign rx_err     = err_flag_q | rx_bad;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    rd_d       = rd_q;
    err_flag_d = err_flag_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    sready_d   = sready_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_o_d    = 32'h0;

    unique case (state_q)
      StIdle: begin
        sready_d = 1'b1;
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          adr_d      = bus.wb_adr_i;
          dat_d      = bus.wb_dat_i;
          we_d       = bus.wb_we_i;
          rd_d       = 32'h0;
          err_flag_d = 1'b0;
          idx_d      = 4'd0;
          tdata_d    = frame_byte(bus.wb_we_i, bus.wb_adr_i, bus.wb_dat_i, 4'd0);
          tvalid_d   = 1'b1;
          sready_d   = 1'b0;
          state_d    = StTx;
        end
      end
      StTx: begin
        if (tvalid_q && bus.m_axis_tready) begin
          if (idx_q == tx_last) begin
            tvalid_d = 1'b0;
            tdata_d  = 8'h00;
            idx_d    = 4'd0;
            timer_d  = '0;
            sready_d = 1'b1;
            state_d  = StRx;
          end else begin
            idx_d   = idx_q + 4'd1;
            tdata_d = frame_byte(we_q, adr_q, dat_q, idx_q + 4'd1);
          end
        end
      end
      StRx: begin
        if (rx_fire) begin
          timer_d    = '0;
          idx_d      = idx_q + 4'd1;
          err_flag_d = rx_err;
          if (idx_q >= 4'd7) rd_d = {rd_q[23:0], bus.s_axis_tdata};
          if (idx_q == rx_last) begin
            state_d  = StResp;
            sready_d = 1'b0;
            ack_d    = bus.wb_cyc_i & ~rx_err;
            err_d    = bus.wb_cyc_i & rx_err;
            dat_o_d  = (bus.wb_cyc_i && !rx_err && !we_q) ? rd_d : 32'h0;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d    = StResp;
          sready_d   = 1'b0;
          err_flag_d = 1'b1;
          err_d      = bus.wb_cyc_i;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        state_d    = StIdle;
        sready_d   = 1'b1;
        err_flag_d = 1'b0;
        idx_d      = 4'd0;
        timer_d    = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      we_q       <= 1'b0;
      rd_q       <= 32'h0;
      err_flag_q <= 1'b0;
      idx_q      <= 4'd0;
      timer_q    <= '0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      sready_q   <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_o_q    <= 32'h0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      err_flag_q <= err_flag_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      sready_q   <= sready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_o_q    <= dat_o_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.s_axis_tready = sready_q;
  assign bus.wb_ack_o      = ack_q;
  assign bus.wb_err_o      = err_q;
  assign bus.wb_dat_o      = dat_o_q;
  assign o_busy            = busy_q;
endmodule
